multicycle_control: RTL
=======================

Name: multicycle_control

Overview:
- Multi-cycle sequencer for the MIPS-subset datapath. Replaces single-cycle opcode decode with an FSM that steps each instruction through fetch, decode, execute and writeback.
- Drives the same datapath controls the single-cycle decoder drives (RegDst, ALUsrc, Br, ALUop, ZeroCheck), plus register-enable strobes.
- Adds a memory-ready stall on fetch, an illegal-opcode trap, and a retired-instruction counter.

Parameters:
CNT_W, 16, width of retired-instruction counter

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
opcode  in  6  instr[31:26] from instruction register
zero  in  1  ALU zero flag
mem_ready  in  1  instruction memory data valid this cycle
IRWrite  out  1  load instruction register
PCWrite  out  1  load PC (PC+4 in FETCH, branch target in BRANCH)
PCSrc  out  1  0 = PC+4, 1 = branch target
RegWrite  out  1  register file write enable
RegDst  out  1  1 = rd, 0 = rt
ALUsrc  out  1  1 = sign/zero-extended immediate
ALUop  out  2  00 add, 01 sub (compare), 10 R-type funct, 11 logic-immediate (ALU uses opcode[0]: 0 and, 1 or)
Br  out  1  branch instruction in progress
ZeroCheck  out  1  0 = beq (take on zero=1), 1 = bne (take on zero=0)
illegal  out  1  sticky trap flag
retired  out  CNT_W  count of completed instructions
state  out  3  current state encoding, for debug

Behaviour:
- Reset is synchronous. With reset=1 at a rising edge: state<=FETCH, class register<=0, retired<=0, illegal<=0. While reset is high, all control outputs are forced to 0.
- State encoding: FETCH=0, DECODE=1, EXEC_R=2, EXEC_I=3, BRANCH=4, WB_R=5, WB_I=6, TRAP=7.
- Outputs not listed for a state are 0.
- FETCH:
  - If mem_ready=0: stay in FETCH; all strobes 0.
  - If mem_ready=1: IRWrite=1, PCWrite=1, PCSrc=0; next state DECODE.
  - IRWrite and PCWrite here are combinational on mem_ready (Mealy).
- DECODE: register the opcode class, then branch on opcode:
  - 000000 -> EXEC_R
  - 001000 -> EXEC_I, class add
  - 001100 -> EXEC_I, class logic
  - 001101 -> EXEC_I, class logic
  - 000100 -> BRANCH, ZeroCheck class 0
  - 000101 -> BRANCH, ZeroCheck class 1
  - any other opcode -> TRAP
- EXEC_R: RegDst=1, ALUsrc=0, ALUop=10. Next state WB_R.
- EXEC_I: ALUsrc=1, RegDst=0; ALUop=00 for addi, 11 for andi/ori. Next state WB_I.
- WB_R / WB_I:
  - Hold the same RegDst/ALUsrc/ALUop as the preceding EXEC state, plus RegWrite=1 for exactly one cycle.
  - retired increments; next state FETCH.
- BRANCH:
  - Drives Br=1, ALUsrc=0, ALUop=01, ZeroCheck per class.
  - taken = zero XOR ZeroCheck. PCWrite=taken, PCSrc=1.
  - retired increments; next state FETCH.
- TRAP: illegal=1; all strobes 0. Remains in TRAP until reset; opcode and mem_ready are ignored.
- Latency with mem_ready=1 in fetch: R-type and immediate take 4 cycles; branch takes 3 cycles. Each stalled cycle adds 1.
- Opcode is sampled only in DECODE; changes in other states have no effect.
- retired wraps from 2^CNT_W-1 to 0 without any flag.
- Reset asserted mid-instruction (any state) aborts it at that edge: no RegWrite or PCWrite in that cycle, and the count is not incremented.
- No state asserts RegWrite and PCWrite in the same cycle.
- IRWrite is asserted only in FETCH.

Test Plan:
- Reset, then mem_ready=1, opcode=000000 -> states 0,1,2,5,0. WB_R: RegWrite=1, RegDst=1, ALUop=10. retired=1 after cycle 4.
- opcode=001100 (andi), mem_ready low for 3 cycles, then high -> FETCH held 3 cycles with IRWrite=0 and PCWrite=0. EXEC_I: ALUsrc=1, ALUop=11. Total 7 cycles; RegWrite pulses once.
- beq (000100) with zero=1 -> BRANCH cycle: Br=1, ZeroCheck=0, PCWrite=1, PCSrc=1. Same instruction with zero=0 -> PCWrite=0. Both return to FETCH after 3 cycles.
- bne (000101) with zero=0 -> ZeroCheck=1, PCWrite=1. With zero=1 -> PCWrite=0.
- opcode=100011 (unsupported) -> TRAP (state=7), illegal=1. Stays there for 20 cycles under any inputs. reset=1 for one edge -> state=0, illegal=0, retired=0.
- CNT_W=2: run 5 addi instructions -> retired sequence 1,2,3,0,1. Assert reset during EXEC_I -> next cycle state=0, no RegWrite pulse, retired=0.

Source files
------------

// File: rtl/multicycle_control.sv
// Multi-cycle sequencer for the MIPS-subset datapath.
// Steps each instruction through fetch, decode, execute and writeback.
// Also provides a fetch stall on memory-not-ready, an illegal-opcode
// trap and a retired-instruction counter.
module multicycle_control #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic             PCSrc,
  output logic             RegWrite,
  output logic             RegDst,
  output logic             ALUsrc,
  output logic [1:0]       ALUop,
  output logic             Br,
  output logic             ZeroCheck,
  output logic             illegal,
  output logic [CNT_W-1:0] retired,
  output logic [2:0]       state
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC_R = 3'd2,
    EXEC_I = 3'd3,
    BRANCH = 3'd4,
    WB_R   = 3'd5,
    WB_I   = 3'd6,
    TRAP   = 3'd7
  } state_t;

  state_t           st;
  // Opcode class captured in DECODE: for immediates 0 = add, 1 = logic;
  // for branches 0 = beq, 1 = bne.
  logic             cls;
  logic             illegal_q;
  logic [CNT_W-1:0] cnt;

  // State sequencing, opcode-class capture, trap flag and retire counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      st        <= FETCH;
      cls       <= 1'b0;
      cnt       <= '0;
      illegal_q <= 1'b0;
    end else begin
      unique case (st)
        FETCH: begin
          if (mem_ready) st <= DECODE;
        end
        DECODE: begin
          unique case (opcode)
            6'b000000: begin st <= EXEC_R; cls <= 1'b0; end
            6'b001000: begin st <= EXEC_I; cls <= 1'b0; end
            6'b001100: begin st <= EXEC_I; cls <= 1'b1; end
            6'b001101: begin st <= EXEC_I; cls <= 1'b1; end
            6'b000100: begin st <= BRANCH; cls <= 1'b0; end
            6'b000101: begin st <= BRANCH; cls <= 1'b1; end
            default: begin
              st        <= TRAP;
              illegal_q <= 1'b1;
            end
          endcase
        end
        EXEC_R: st <= WB_R;
        EXEC_I: st <= WB_I;
        WB_R, WB_I, BRANCH: begin
          st  <= FETCH;
          cnt <= cnt + CNT_W'(1);
        end
        TRAP: st <= TRAP;
        default: st <= FETCH;
      endcase
    end
  end

  // Datapath controls decoded from state; FETCH strobes follow mem_ready and
  // the branch PC write follows zero within the cycle. Reset forces all to 0.
  always_comb begin
    IRWrite   = 1'b0;
    PCWrite   = 1'b0;
    PCSrc     = 1'b0;
    RegWrite  = 1'b0;
    RegDst    = 1'b0;
    ALUsrc    = 1'b0;
    ALUop     = 2'b00;
    Br        = 1'b0;
    ZeroCheck = 1'b0;
    if (!reset) begin
      unique case (st)
        FETCH: begin
          IRWrite = mem_ready;
          PCWrite = mem_ready;
        end
        EXEC_R: begin
          RegDst = 1'b1;
          ALUop  = 2'b10;
        end
        WB_R: begin
          RegDst   = 1'b1;
          ALUop    = 2'b10;
          RegWrite = 1'b1;
        end
        EXEC_I: begin
          ALUsrc = 1'b1;
          ALUop  = cls ? 2'b11 : 2'b00;
        end
        WB_I: begin
          ALUsrc   = 1'b1;
          ALUop    = cls ? 2'b11 : 2'b00;
          RegWrite = 1'b1;
        end
        BRANCH: begin
          Br        = 1'b1;
          ALUop     = 2'b01;
          ZeroCheck = cls;
          PCWrite   = zero ^ cls;
          PCSrc     = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign illegal = illegal_q & ~reset;
  assign retired = cnt;
  assign state   = st;

endmodule
